// File: rtl/alfa_monu_axil_regs.sv
// AXI4-Lite register bank for the ALFA Monitoring Unit: status words 0..31 (read-only),
// control words 32..NUM_REGS-1 (read/write), plus the one-cycle start pulse to the core.
module alfa_monu_axil_regs #(
    parameter int ADDR_WIDTH = 12,
    parameter int NUM_REGS   = 64
) (
    input  logic                  i_SYSTEM_clk,
    input  logic                  i_SYSTEM_rst,
    input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
    input  logic                  s_axi_awvalid,
    output logic                  s_axi_awready,
    input  logic [31:0]           s_axi_wdata,
    input  logic [3:0]            s_axi_wstrb,
    input  logic                  s_axi_wvalid,
    output logic                  s_axi_wready,
    output logic [1:0]            s_axi_bresp,
    output logic                  s_axi_bvalid,
    input  logic                  s_axi_bready,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [31:0]           s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    input  logic                  i_unit_busy,
    input  logic                  i_unit_done,
    input  logic [31:0]           i_points_processed,
    output logic                  o_pc_ready_pulse,
    output logic [31:0]           o_pc_size,
    output logic [31:0]           o_filter_min,
    output logic [31:0]           o_filter_max
);

    localparam int IDXW         = ADDR_WIDTH - 2;
    localparam int CTRL_BASE    = 32;
    localparam int NCTRL        = NUM_REGS - CTRL_BASE;
    localparam int IDX_BUSY     = 8;
    localparam int IDX_DONE     = 9;
    localparam int IDX_POINTS   = 10;
    localparam int IDX_PC_READY = 35;
    localparam int IDX_PC_SIZE  = 37;
    localparam int IDX_FMIN     = 40;
    localparam int IDX_FMAX     = 41;

    logic                  aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
    logic                  w_held_q, w_held_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic                  bvalid_q, bvalid_d;
    logic [1:0]            bresp_q, bresp_d;
    logic                  rvalid_q, rvalid_d;
    logic [1:0]            rresp_q, rresp_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  pulse_q, pulse_d;
    logic                  done_q, done_d;
    logic [31:0]           ctrl_q [NCTRL];
    logic [31:0]           ctrl_d [NCTRL];

    logic            aw_hs, w_hs, ar_hs, b_hs, r_hs;
    logic            wr_exec, wr_err, rd_err, start_fire;
    logic [IDXW-1:0] widx, ridx;
    logic [31:0]     rd_word;
    logic            unused_addr_bits;

    assign s_axi_awready = !aw_held_q && !bvalid_q;
    assign s_axi_wready  = !w_held_q && !bvalid_q;
    assign s_axi_arready = !rvalid_q;
    assign s_axi_bvalid  = bvalid_q;
    assign s_axi_bresp   = bresp_q;
    assign s_axi_rvalid  = rvalid_q;
    assign s_axi_rresp   = rresp_q;
    assign s_axi_rdata   = rdata_q;

    assign o_pc_ready_pulse = pulse_q;
    assign o_pc_size        = ctrl_q[IDX_PC_SIZE - CTRL_BASE];
    assign o_filter_min     = ctrl_q[IDX_FMIN - CTRL_BASE];
    assign o_filter_max     = ctrl_q[IDX_FMAX - CTRL_BASE];

    assign unused_addr_bits = ^{s_axi_awaddr[1:0], s_axi_araddr[1:0]};

    assign aw_hs = s_axi_awvalid && s_axi_awready;
    assign w_hs  = s_axi_wvalid && s_axi_wready;
    assign ar_hs = s_axi_arvalid && s_axi_arready;
    assign b_hs  = bvalid_q && s_axi_bready;
    assign r_hs  = rvalid_q && s_axi_rready;

    assign widx    = awaddr_q[ADDR_WIDTH-1:2];
    assign ridx    = s_axi_araddr[ADDR_WIDTH-1:2];
    assign wr_err  = int'(widx) >= NUM_REGS;
    assign rd_err  = int'(ridx) >= NUM_REGS;
    // The write runs only from the holding registers, so it lands one edge after the later handshake.
    assign wr_exec = aw_held_q && w_held_q && !bvalid_q;

    // The start pulse fires only on a 0->1 edge of the stored PC_ready bit.
    assign start_fire = wr_exec && (int'(widx) == IDX_PC_READY) && wstrb_q[0] && wdata_q[0]
                        && !ctrl_q[IDX_PC_READY - CTRL_BASE][0];

    always_comb begin
        aw_held_d = aw_held_q;
        awaddr_d  = awaddr_q;
        w_held_d  = w_held_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        if (aw_hs) begin
            aw_held_d = 1'b1;
            awaddr_d  = s_axi_awaddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            wdata_d  = s_axi_wdata;
            wstrb_d  = s_axi_wstrb;
        end
        if (wr_exec) begin
            bvalid_d = 1'b1;
            bresp_d  = wr_err ? 2'b10 : 2'b00;
        end else if (b_hs) begin
            bvalid_d  = 1'b0;
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
        end
    end

    always_comb begin
        for (int i = 0; i < NCTRL; i++) begin
            ctrl_d[i] = ctrl_q[i];
            if (wr_exec && !wr_err && (int'(widx) == i + CTRL_BASE)) begin
                for (int b = 0; b < 4; b++) begin
                    if (wstrb_q[b]) begin
                        ctrl_d[i][8*b +: 8] = wdata_q[8*b +: 8];
                    end
                end
            end
        end
        pulse_d = start_fire;
        // A done event in the same cycle as a start must survive, so set has priority.
        if (i_unit_done) begin
            done_d = 1'b1;
        end else if (start_fire) begin
            done_d = 1'b0;
        end else begin
            done_d = done_q;
        end
    end

    always_comb begin
        rd_word = 32'h0;
        if (int'(ridx) == IDX_BUSY) begin
            rd_word = {31'b0, i_unit_busy};
        end else if (int'(ridx) == IDX_DONE) begin
            rd_word = {31'b0, done_q};
        end else if (int'(ridx) == IDX_POINTS) begin
            rd_word = i_points_processed;
        end else begin
            for (int i = 0; i < NCTRL; i++) begin
                if (int'(ridx) == i + CTRL_BASE) begin
                    rd_word = ctrl_q[i];
                end
            end
        end
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_word;
            rresp_d  = rd_err ? 2'b10 : 2'b00;
        end else if (r_hs) begin
            rvalid_d = 1'b0;
        end
    end

    always_ff @(posedge i_SYSTEM_clk or negedge i_SYSTEM_rst) begin
        if (!i_SYSTEM_rst) begin
            aw_held_q <= 1'b0;
            awaddr_q  <= '0;
            w_held_q  <= 1'b0;
            wdata_q   <= 32'h0;
            wstrb_q   <= 4'h0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            rvalid_q  <= 1'b0;
            rresp_q   <= 2'b00;
            rdata_q   <= 32'h0;
            pulse_q   <= 1'b0;
            done_q    <= 1'b0;
            ctrl_q    <= '{default: '0};
        end else begin
            aw_held_q <= aw_held_d;
            awaddr_q  <= awaddr_d;
            w_held_q  <= w_held_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rresp_q   <= rresp_d;
            rdata_q   <= rdata_d;
            pulse_q   <= pulse_d;
            done_q    <= done_d;
            ctrl_q    <= ctrl_d;
        end
    end

endmodule

// File: tb/tb_alfa_monu_axil_regs.sv
// Directed bench for alfa_monu_axil_regs: expected B/R responses are queued when a transaction
// is issued and popped when the DUT responds.
module tb_alfa_monu_axil_regs;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic [11:0] awAddr = '0;
    logic        awValid = 1'b0;
    logic        awReady;
    logic [31:0] wData = '0;
    logic [3:0]  wStrb = '0;
    logic        wValid = 1'b0;
    logic        wReady;
    logic [1:0]  bResp;
    logic        bValid;
    logic        bReady = 1'b0;
    logic [11:0] arAddr = '0;
    logic        arValid = 1'b0;
    logic        arReady;
    logic [31:0] rData;
    logic [1:0]  rResp;
    logic        rValid;
    logic        rReady = 1'b0;
    logic        unitBusy = 1'b0;
    logic        unitDone = 1'b0;
    logic [31:0] pointsProcessed = '0;
    logic        pcReadyPulse;
    logic [31:0] pcSize, filterMin, filterMax;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } readExp_t;

    logic [1:0] bExpQ[$];
    readExp_t   rExpQ[$];
    int compared = 0;
    int mismatched = 0;
    int pulseCycles = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (pcReadyPulse) pulseCycles++;
    end

    alfa_monu_axil_regs #(.ADDR_WIDTH(12), .NUM_REGS(64)) dut (
        .i_SYSTEM_clk      (clock),
        .i_SYSTEM_rst      (resetN),
        .s_axi_awaddr      (awAddr),
        .s_axi_awvalid     (awValid),
        .s_axi_awready     (awReady),
        .s_axi_wdata       (wData),
        .s_axi_wstrb       (wStrb),
        .s_axi_wvalid      (wValid),
        .s_axi_wready      (wReady),
        .s_axi_bresp       (bResp),
        .s_axi_bvalid      (bValid),
        .s_axi_bready      (bReady),
        .s_axi_araddr      (arAddr),
        .s_axi_arvalid     (arValid),
        .s_axi_arready     (arReady),
        .s_axi_rdata       (rData),
        .s_axi_rresp       (rResp),
        .s_axi_rvalid      (rValid),
        .s_axi_rready      (rReady),
        .i_unit_busy       (unitBusy),
        .i_unit_done       (unitDone),
        .i_points_processed(pointsProcessed),
        .o_pc_ready_pulse  (pcReadyPulse),
        .o_pc_size         (pcSize),
        .o_filter_min      (filterMin),
        .o_filter_max      (filterMax)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic busy, input logic [31:0] points);
        @(negedge clock);
        unitBusy = busy;
        pointsProcessed = points;
    endtask

    task automatic pulseDone();
        @(negedge clock);
        unitDone = 1'b1;
        @(negedge clock);
        unitDone = 1'b0;
    endtask

    task automatic waitB(input string tag);
        int n = 0;
        logic [1:0] exp;
        @(negedge clock);
        while (!bValid && n < 20) begin
            @(negedge clock);
            n++;
        end
        checkOutput({tag, " bvalid"}, {31'b0, bValid}, 32'd1);
        if (bValid && bExpQ.size() > 0) begin
            exp = bExpQ.pop_front();
            checkOutput({tag, " bresp"}, {30'b0, bResp}, {30'b0, exp});
        end
        bReady = 1'b1;
        @(posedge clock);
        #1;
    endtask

    task automatic axiWrite(input string tag, input logic [11:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] expResp, input bit withDone);
        int n = 0;
        bExpQ.push_back(expResp);
        @(negedge clock);
        awAddr = addr;
        awValid = 1'b1;
        wData = data;
        wStrb = strb;
        wValid = 1'b1;
        bReady = 1'b1;
        while (!(awReady && wReady) && n < 20) begin
            @(negedge clock);
            n++;
        end
        checkOutput({tag, " aw/w ready"}, {31'b0, awReady && wReady}, 32'd1);
        @(posedge clock);
        #1;
        awValid = 1'b0;
        wValid = 1'b0;
        // Hold done across the execution edge that follows the handshake edge.
        if (withDone) begin
            unitDone = 1'b1;
            @(posedge clock);
            #1;
            unitDone = 1'b0;
        end
        waitB(tag);
    endtask

    task automatic axiRead(input string tag, input logic [11:0] addr, input logic [31:0] expData,
                           input logic [1:0] expResp);
        int n = 0;
        readExp_t exp;
        rExpQ.push_back('{data: expData, resp: expResp});
        @(negedge clock);
        arAddr = addr;
        arValid = 1'b1;
        rReady = 1'b1;
        while (!arReady && n < 20) begin
            @(negedge clock);
            n++;
        end
        @(posedge clock);
        #1;
        arValid = 1'b0;
        n = 0;
        @(negedge clock);
        while (!rValid && n < 20) begin
            @(negedge clock);
            n++;
        end
        checkOutput({tag, " rvalid"}, {31'b0, rValid}, 32'd1);
        if (rValid && rExpQ.size() > 0) begin
            exp = rExpQ.pop_front();
            checkOutput({tag, " rdata"}, rData, exp.data);
            checkOutput({tag, " rresp"}, {30'b0, rResp}, {30'b0, exp.resp});
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        int p0;
        int n;
        $display("[TB] starting alfa_monu_axil_regs bench");

        repeat (2) @(negedge clock);
        checkOutput("reset awready", {31'b0, awReady}, 32'd1);
        checkOutput("reset wready", {31'b0, wReady}, 32'd1);
        checkOutput("reset arready", {31'b0, arReady}, 32'd1);
        checkOutput("reset bvalid", {31'b0, bValid}, 32'd0);
        checkOutput("reset rvalid", {31'b0, rValid}, 32'd0);
        checkOutput("reset rdata", rData, 32'd0);
        checkOutput("reset pulse", {31'b0, pcReadyPulse}, 32'd0);
        checkOutput("reset pc_size", pcSize, 32'd0);
        resetN = 1'b1;

        axiWrite("wr pc_size", 12'h094, 32'd1000, 4'hF, 2'b00, 1'b0);
        axiWrite("wr fmin", 12'h0A0, 32'd500, 4'hF, 2'b00, 1'b0);
        axiWrite("wr fmax", 12'h0A4, 32'd1000, 4'hF, 2'b00, 1'b0);
        checkOutput("o_pc_size", pcSize, 32'd1000);
        checkOutput("o_filter_min", filterMin, 32'd500);
        checkOutput("o_filter_max", filterMax, 32'd1000);
        axiRead("rd pc_size", 12'h094, 32'd1000, 2'b00);
        axiRead("rd fmin", 12'h0A0, 32'd500, 2'b00);
        axiRead("rd fmax", 12'h0A4, 32'd1000, 2'b00);

        p0 = pulseCycles;
        axiWrite("wr start 0", 12'h08C, 32'd0, 4'hF, 2'b00, 1'b0);
        @(negedge clock);
        checkOutput("no pulse on 0", pulseCycles - p0, 32'd0);
        axiWrite("wr start 1", 12'h08C, 32'd1, 4'hF, 2'b00, 1'b0);
        @(negedge clock);
        checkOutput("one pulse on 0->1", pulseCycles - p0, 32'd1);
        axiWrite("wr start 1 again", 12'h08C, 32'd1, 4'hF, 2'b00, 1'b0);
        @(negedge clock);
        checkOutput("no pulse on 1->1", pulseCycles - p0, 32'd1);
        axiRead("rd pc_ready", 12'h08C, 32'd1, 2'b00);

        applyStimulus(1'b1, 32'h1234_5678);
        axiRead("rd busy=1", 12'h020, 32'd1, 2'b00);
        axiRead("rd points", 12'h028, 32'h1234_5678, 2'b00);
        applyStimulus(1'b0, 32'h0000_0042);
        axiRead("rd busy=0", 12'h020, 32'd0, 2'b00);

        axiRead("rd done init", 12'h024, 32'd0, 2'b00);
        pulseDone();
        axiRead("rd done sticky", 12'h024, 32'd1, 2'b00);
        axiWrite("wr start 0 b", 12'h08C, 32'd0, 4'hF, 2'b00, 1'b0);
        axiRead("rd done after 0", 12'h024, 32'd1, 2'b00);
        p0 = pulseCycles;
        axiWrite("wr start 1 b", 12'h08C, 32'd1, 4'hF, 2'b00, 1'b0);
        @(negedge clock);
        checkOutput("pulse clears done", pulseCycles - p0, 32'd1);
        axiRead("rd done cleared", 12'h024, 32'd0, 2'b00);
        axiWrite("wr start 0 c", 12'h08C, 32'd0, 4'hF, 2'b00, 1'b0);
        p0 = pulseCycles;
        axiWrite("wr start+done", 12'h08C, 32'd1, 4'hF, 2'b00, 1'b1);
        @(negedge clock);
        checkOutput("pulse with done", pulseCycles - p0, 32'd1);
        axiRead("rd done set wins", 12'h024, 32'd1, 2'b00);

        axiWrite("wr status", 12'h014, 32'hDEAD_BEEF, 4'hF, 2'b00, 1'b0);
        axiRead("rd status", 12'h014, 32'd0, 2'b00);

        // Data arrives well ahead of the address, and the B channel is back-pressured.
        bExpQ.push_back(2'b00);
        @(negedge clock);
        wData = 32'h1357_9BDF;
        wStrb = 4'hF;
        wValid = 1'b1;
        bReady = 1'b0;
        @(posedge clock);
        #1;
        wValid = 1'b0;
        @(negedge clock);
        checkOutput("wready while W held", {31'b0, wReady}, 32'd0);
        checkOutput("awready while W held", {31'b0, awReady}, 32'd1);
        checkOutput("no early bvalid", {31'b0, bValid}, 32'd0);
        @(negedge clock);
        @(negedge clock);
        awAddr = 12'h0B4;
        awValid = 1'b1;
        @(posedge clock);
        #1;
        awValid = 1'b0;
        n = 0;
        @(negedge clock);
        while (!bValid && n < 20) begin
            @(negedge clock);
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            checkOutput("bvalid held", {31'b0, bValid}, 32'd1);
            checkOutput("awready low in B", {31'b0, awReady}, 32'd0);
            checkOutput("wready low in B", {31'b0, wReady}, 32'd0);
            @(negedge clock);
        end
        if (bExpQ.size() > 0) checkOutput("late-aw bresp", {30'b0, bResp}, {30'b0, bExpQ.pop_front()});
        bReady = 1'b1;
        @(negedge clock);
        checkOutput("bvalid released", {31'b0, bValid}, 32'd0);
        checkOutput("awready released", {31'b0, awReady}, 32'd1);
        checkOutput("wready released", {31'b0, wReady}, 32'd1);
        axiRead("rd late-aw word", 12'h0B4, 32'h1357_9BDF, 2'b00);

        axiWrite("wr strobe", 12'h0C8, 32'hAABB_CCDD, 4'b0101, 2'b00, 1'b0);
        axiRead("rd strobe", 12'h0C8, 32'h00BB_00DD, 2'b00);

        axiWrite("wr oob", 12'h100, 32'hFFFF_FFFF, 4'hF, 2'b10, 1'b0);
        axiRead("rd oob", 12'h100, 32'd0, 2'b10);
        axiRead("rd word32 after oob", 12'h080, 32'd0, 2'b00);
        checkOutput("pc_size after oob", pcSize, 32'd1000);
        checkOutput("fmax after oob", filterMax, 32'd1000);

        axiWrite("wr start 0 d", 12'h08C, 32'd0, 4'hF, 2'b00, 1'b0);
        p0 = pulseCycles;
        @(negedge clock);
        awAddr = 12'h08C;
        awValid = 1'b1;
        wData = 32'd1;
        wStrb = 4'hF;
        wValid = 1'b1;
        @(posedge clock);
        #1;
        awValid = 1'b0;
        wValid = 1'b0;
        #1;
        resetN = 1'b0;
        @(negedge clock);
        checkOutput("mid-reset bvalid", {31'b0, bValid}, 32'd0);
        checkOutput("mid-reset awready", {31'b0, awReady}, 32'd1);
        checkOutput("mid-reset pc_size", pcSize, 32'd0);
        resetN = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("no pulse after reset", pulseCycles - p0, 32'd0);
        checkOutput("no bvalid after reset", {31'b0, bValid}, 32'd0);
        axiRead("rd pc_ready after reset", 12'h08C, 32'd0, 2'b00);
        axiRead("rd done after reset", 12'h024, 32'd0, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
